// File: rtl/i2c_slave_ram_engine_pkg.sv
// Shared definitions for the I2C slave RAM engine: FSM states, ACK/NACK levels
// and the character RAM address width.
package i2c_common_defs;

  localparam int RAM_AW = 5;

  localparam logic ACK_BIT  = 1'b0;
  localparam logic NACK_BIT = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    WR_BYTE = 3'd2,
    RD_BYTE = 3'd3,
    RD_ACK  = 3'd4,
    IGNORE  = 3'd5
  } state_t;

endpackage

// File: rtl/i2c_slave_ram_engine_line_filter.sv
// Pad conditioning for one I2C line: 2-flop synchronizer, FILTER_LEN-sample
// glitch filter and one-clk rise/fall strobes of the filtered level.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0]            sync;
  logic [FILTER_LEN-1:0] hist;

  // The idle bus is high, so everything resets high to avoid a false edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= 2'b11;
      hist  <= '1;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      hist <= (hist << 1) | FILTER_LEN'(sync[1]);
      rise <= 1'b0;
      fall <= 1'b0;
      if (hist == '1 && !level) begin
        level <= 1'b1;
        rise  <= 1'b1;
      end else if (hist == '0 && level) begin
        level <= 1'b0;
        fall  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_ram_engine.sv
// I2C slave engine: master writes land in Remote RAM, master reads stream Local RAM.
// Optional macro I2C_SLAVE_PTR_BYTE_EN makes the first written byte a RAM pointer.
module i2c_slave_ram_engine
  import i2c_common_defs::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h22,
  parameter int         FILTER_LEN = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SCL_IN,
  input  logic              SDA_IN,
  output logic              SDA_OE,
  output logic [RAM_AW-1:0] RemoteRAM_WADD,
  output logic [7:0]        RemoteRAM_DIN,
  output logic              RemoteRAM_W,
  output logic [RAM_AW-1:0] LocalRAM_RADD,
  input  logic [7:0]        LocalRAM_DOUT,
  output logic              Busy,
  output logic              Xfer_Done
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk(clk), .reset(reset), .raw(SCL_IN),
    .level(scl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk(clk), .reset(reset), .raw(SDA_IN),
    .level(sda), .rise(sda_rise), .fall(sda_fall)
  );

  logic start_evt, stop_evt;
  assign start_evt = sda_fall & scl;
  assign stop_evt  = sda_rise & scl;

  state_t            state;
  logic [3:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [7:0]        rx_byte;
  logic              ack_phase;
  logic              rw;
  logic [RAM_AW-1:0] ptr;
`ifdef I2C_SLAVE_PTR_BYTE_EN
  logic              ptr_pending;
`endif

  assign rx_byte       = {shreg[6:0], sda};
  assign LocalRAM_RADD = ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      shreg          <= '0;
      ack_phase      <= 1'b0;
      rw             <= 1'b0;
      ptr            <= '0;
      SDA_OE         <= 1'b0;
      RemoteRAM_W    <= 1'b0;
      RemoteRAM_WADD <= '0;
      RemoteRAM_DIN  <= '0;
      Busy           <= 1'b0;
      Xfer_Done      <= 1'b0;
`ifdef I2C_SLAVE_PTR_BYTE_EN
      ptr_pending    <= 1'b0;
`endif
    end else begin
      RemoteRAM_W <= 1'b0;
      Xfer_Done   <= 1'b0;
      // Bus conditions override any SCL edge seen in the same clk.
      if (stop_evt) begin
        state     <= IDLE;
        SDA_OE    <= 1'b0;
        ack_phase <= 1'b0;
        bit_cnt   <= '0;
        Xfer_Done <= Busy;
        Busy      <= 1'b0;
      end else if (start_evt) begin
        state     <= ADDR;
        SDA_OE    <= 1'b0;
        ack_phase <= 1'b0;
        bit_cnt   <= '0;
      end else begin
        case (state)
          IDLE: ;
          ADDR, WR_BYTE: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (state == ADDR) begin
                  if (rx_byte[7:1] == SLAVE_ADDR) begin
                    rw   <= rx_byte[0];
                    Busy <= 1'b1;
`ifdef I2C_SLAVE_PTR_BYTE_EN
                    if (!Busy) ptr <= '0;
                    ptr_pending <= ~rx_byte[0];
`else
                    ptr <= '0;
`endif
                  end else begin
                    state <= IGNORE;
                  end
                end else begin
`ifdef I2C_SLAVE_PTR_BYTE_EN
                  if (ptr_pending) begin
                    ptr         <= rx_byte[RAM_AW-1:0];
                    ptr_pending <= 1'b0;
                  end else begin
                    RemoteRAM_W    <= 1'b1;
                    RemoteRAM_WADD <= ptr;
                    RemoteRAM_DIN  <= rx_byte;
                    ptr            <= ptr + RAM_AW'(1);
                  end
`else
                  RemoteRAM_W    <= 1'b1;
                  RemoteRAM_WADD <= ptr;
                  RemoteRAM_DIN  <= rx_byte;
                  ptr            <= ptr + RAM_AW'(1);
`endif
                end
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (!ack_phase) begin
                SDA_OE    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= '0;
                // A read starts driving its MSB on the same fall that ends the ACK.
                if (state == ADDR && rw) begin
                  state  <= RD_BYTE;
                  shreg  <= LocalRAM_DOUT;
                  SDA_OE <= ~LocalRAM_DOUT[7];
                end else begin
                  state  <= WR_BYTE;
                  SDA_OE <= 1'b0;
                end
              end
            end
          end
          RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd0) begin
                shreg  <= LocalRAM_DOUT;
                SDA_OE <= ~LocalRAM_DOUT[7];
              end else if (bit_cnt < 4'd8) begin
                shreg  <= shreg << 1;
                SDA_OE <= ~shreg[6];
              end else begin
                SDA_OE  <= 1'b0;
                ptr     <= ptr + RAM_AW'(1);
                bit_cnt <= '0;
                state   <= RD_ACK;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) state <= (sda == ACK_BIT) ? RD_BYTE : IGNORE;
          end
          IGNORE: SDA_OE <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
